// File: rtl/msgdma_frame_sequencer_if.sv
// Dispatcher-facing buses of the frame sequencer: CSR status read port and descriptor write slave.
interface msgdma_frame_sequencer_if;
  logic [2:0]  csr_address;
  logic        csr_read;
  logic        csr_waitrequest;
  logic [31:0] csr_readdata;
  logic [1:0]  desc_address;
  logic        desc_write;
  logic [31:0] desc_writedata;
  logic        desc_waitrequest;

  modport master (
    output csr_address, csr_read,
    input  csr_waitrequest, csr_readdata,
    output desc_address, desc_write, desc_writedata,
    input  desc_waitrequest
  );

  modport slave (
    input  csr_address, csr_read,
    output csr_waitrequest, csr_readdata,
    input  desc_address, desc_write, desc_writedata,
    output desc_waitrequest
  );
endinterface

// File: rtl/msgdma_frame_sequencer.sv
// Writes one mSGDMA descriptor per frame line (SOP on line 0, EOP on last); FRAME_SEQ_DOUBLE_BUFFER_EN alternates frame bases.
// Latency: start -> csr_read next cycle; 7 cycles per descriptor minimum, all outputs registered.
// Backpressure: re-polls while dispatcher buffer full; each descriptor word held until waitrequest is low.
module msgdma_frame_sequencer #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned LINE_BYTES   = 4096,
  parameter int unsigned STRIDE_BYTES = 4096,
  parameter int unsigned NUM_LINES    = 1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  msgdma_frame_sequencer_if.master bus
);

  localparam logic [15:0] LAST_LINE = 16'(NUM_LINES - 1);
  localparam logic [31:0] LINE_LEN  = 32'(LINE_BYTES);
  localparam logic [31:0] STRIDE    = 32'(STRIDE_BYTES);

  typedef enum logic [2:0] {
    IDLE, POLL, POLL_WAIT, WR_RADDR, WR_WADDR, WR_LEN, WR_CTRL, NEXT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] line;
  logic [31:0] rd_addr;
  logic        stop_pend;
  logic        csr_read_q;
  logic        desc_write_q;
  logic [1:0]  desc_address_q;
  logic [31:0] desc_writedata_q;
  logic [1:0]  wr_adr_nxt;
  logic [31:0] wr_dat_nxt;
  logic [31:0] cur_base, nxt_base;
  logic        last_line, stop_eff;
  logic        unused_csr_bits;

  assign last_line = (line == LAST_LINE);
  assign stop_eff  = stop_pend | stop;
  assign unused_csr_bits = ^{bus.csr_readdata[31:3], bus.csr_readdata[1:0]};

`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
  localparam logic [31:0] FRAME_BYTES = 32'(NUM_LINES) * STRIDE;
  // Even frame_count reads buffer 0, odd reads buffer 1.
  assign cur_base = frame_count[0] ? BASE_ADDR + FRAME_BYTES : BASE_ADDR;
  assign nxt_base = frame_count[0] ? BASE_ADDR : BASE_ADDR + FRAME_BYTES;
`else
  assign cur_base = BASE_ADDR;
  assign nxt_base = BASE_ADDR;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = POLL;
      POLL:      if (!bus.csr_waitrequest) state_nxt = POLL_WAIT;
      POLL_WAIT: state_nxt = bus.csr_readdata[2] ? POLL : WR_RADDR;
      WR_RADDR:  if (!bus.desc_waitrequest) state_nxt = WR_WADDR;
      WR_WADDR:  if (!bus.desc_waitrequest) state_nxt = WR_LEN;
      WR_LEN:    if (!bus.desc_waitrequest) state_nxt = WR_CTRL;
      WR_CTRL:   if (!bus.desc_waitrequest) state_nxt = NEXT;
      NEXT: begin
        if (last_line) state_nxt = (continuous && !stop_eff) ? POLL : IDLE;
        else           state_nxt = stop_eff ? IDLE : POLL;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Descriptor bus contents are decoded from the upcoming state so they register alongside it.
  always_comb begin
    wr_adr_nxt = 2'd0;
    wr_dat_nxt = 32'd0;
    case (state_nxt)
      WR_RADDR: begin wr_adr_nxt = 2'd0; wr_dat_nxt = rd_addr; end
      WR_WADDR: begin wr_adr_nxt = 2'd1; wr_dat_nxt = 32'd0; end
      WR_LEN:   begin wr_adr_nxt = 2'd2; wr_dat_nxt = LINE_LEN; end
      WR_CTRL: begin
        wr_adr_nxt = 2'd3;
        wr_dat_nxt = {1'b1, 21'd0, last_line, (line == 16'd0), 8'd0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      line             <= 16'd0;
      rd_addr          <= 32'd0;
      stop_pend        <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      frame_count      <= 16'd0;
      csr_read_q       <= 1'b0;
      desc_write_q     <= 1'b0;
      desc_address_q   <= 2'd0;
      desc_writedata_q <= 32'd0;
    end else begin
      state            <= state_nxt;
      busy             <= (state_nxt != IDLE);
      csr_read_q       <= (state_nxt == POLL);
      desc_write_q     <= state_nxt inside {WR_RADDR, WR_WADDR, WR_LEN, WR_CTRL};
      desc_address_q   <= wr_adr_nxt;
      desc_writedata_q <= wr_dat_nxt;
      frame_done       <= 1'b0;
      if (state != IDLE && stop) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            line      <= 16'd0;
            rd_addr   <= cur_base;
            stop_pend <= 1'b0;
          end
        end
        NEXT: begin
          if (last_line) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            line        <= 16'd0;
            rd_addr     <= nxt_base;
          end else begin
            line    <= line + 16'd1;
            rd_addr <= rd_addr + STRIDE;
          end
          if (state_nxt == IDLE) stop_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.csr_address    = 3'd0;
  assign bus.csr_read       = csr_read_q;
  assign bus.desc_write     = desc_write_q;
  assign bus.desc_address   = desc_address_q;
  assign bus.desc_writedata = desc_writedata_q;

endmodule

// File: tb/tb_msgdma_frame_sequencer.sv
// Bench for msgdma_frame_sequencer: dispatcher responder, descriptor scoreboard and directed frame scenarios.
module tb_msgdma_frame_sequencer;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int LB = 64;
  localparam int ST = 128;
  localparam int NL = 3;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, continuous, stop;
  logic        busy, frame_done;
  logic [15:0] frame_count;

  msgdma_frame_sequencer_if bus();

  msgdma_frame_sequencer #(
    .BASE_ADDR(BASE), .LINE_BYTES(LB), .STRIDE_BYTES(ST), .NUM_LINES(NL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] raddr_log[$];
  int checks = 0, errors = 0;
  int full_left = 0, len_stall = 0, polls = 0, fd_pulses = 0, busy_cyc = 0, acc_writes = 0;
  logic        rd_pend = 1'b0, stall_prev = 1'b0;
  logic [1:0]  prev_a;
  logic [31:0] prev_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [1:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    return w;
  endfunction

  // Reference model: frame base and the four words of each line descriptor.
  function automatic logic [31:0] frame_base(input int fc);
    return (DB && fc[0]) ? BASE + 32'(NL * ST) : BASE;
  endfunction

  task automatic push_frame(input int fc, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      logic [31:0] c;
      c = 32'h8000_0000;
      if (l == 0) c[8] = 1'b1;
      if (l == NL - 1) c[9] = 1'b1;
      exp_q.push_back(mk(2'd0, frame_base(fc) + 32'(l * ST)));
      exp_q.push_back(mk(2'd1, 32'd0));
      exp_q.push_back(mk(2'd2, 32'(LB)));
      exp_q.push_back(mk(2'd3, c));
    end
  endtask

  // Dispatcher responder plus per-cycle compare, all on the falling edge.
  always @(negedge clk) begin
    if (rd_pend) begin
      bus.csr_readdata = (full_left > 0) ? 32'h0000_0004 : 32'h0000_0000;
      if (full_left > 0) full_left--;
      polls++;
    end else begin
      bus.csr_readdata = 32'hFFFF_FFFF;
    end
    rd_pend = bus.csr_read && !bus.csr_waitrequest;
    bus.desc_waitrequest = bus.desc_write && (bus.desc_address == 2'd2) && (len_stall > 0);
    if (bus.desc_waitrequest) len_stall--;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold_stable", {bus.desc_write, bus.desc_address, bus.desc_writedata}, {1'b1, prev_a, prev_d});
      stall_prev = bus.desc_write && bus.desc_waitrequest;
      prev_a = bus.desc_address;
      prev_d = bus.desc_writedata;
      if (full_left > 0) check("no_write_while_full", bus.desc_write, 0);
      if (bus.csr_read || bus.desc_write) check("busy_when_active", busy, 1);
      if (bus.desc_write && !bus.desc_waitrequest) begin
        acc_writes++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%0h/%0h required=none", bus.desc_address, bus.desc_writedata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("desc_word", {bus.desc_address, bus.desc_writedata}, {e.a, e.d});
        end
        if (bus.desc_address == 2'd0) raddr_log.push_back(bus.desc_writedata);
      end
      if (busy) busy_cyc++;
      if (frame_done) fd_pulses++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_csr_read"}, bus.csr_read, 0);
    check({tag, "_csr_address"}, bus.csr_address, 0);
    check({tag, "_desc_write"}, bus.desc_write, 0);
    check({tag, "_desc_address"}, bus.desc_address, 0);
    check({tag, "_desc_writedata"}, bus.desc_writedata, 0);
  endtask

  task automatic pulse_start(input logic with_stop);
    @(negedge clk);
    start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("busy_after_start", busy, 1);
    check("csr_read_after_start", bus.csr_read, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (busy && n < budget);
    check("returns_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    bus.csr_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // Basic frame, literal expected descriptors.
    exp_q.push_back(mk(2'd0, 32'h3000_0000)); exp_q.push_back(mk(2'd1, 32'd0));
    exp_q.push_back(mk(2'd2, 32'd64));        exp_q.push_back(mk(2'd3, 32'h8000_0100));
    exp_q.push_back(mk(2'd0, 32'h3000_0080)); exp_q.push_back(mk(2'd1, 32'd0));
    exp_q.push_back(mk(2'd2, 32'd64));        exp_q.push_back(mk(2'd3, 32'h8000_0000));
    exp_q.push_back(mk(2'd0, 32'h3000_0100)); exp_q.push_back(mk(2'd1, 32'd0));
    exp_q.push_back(mk(2'd2, 32'd64));        exp_q.push_back(mk(2'd3, 32'h8000_0200));
    busy_cyc = 0; fd0 = fd_pulses;
    pulse_start(1'b0);
    wait_idle(100);
    check("s1_frame_count", frame_count, 1);
    check("s1_frame_done_pulses", fd_pulses - fd0, 1);
    check("s1_queue_empty", exp_q.size(), 0);
    check("s1_busy_cycles", busy_cyc, 21);

    // Dispatcher buffer full for ten polls.
    full_left = 10; polls = 0; busy_cyc = 0;
    push_frame(1, NL);
    pulse_start(1'b0);
    wait_idle(200);
    check("s2_frame_count", frame_count, 2);
    check("s2_polls", polls, 13);
    check("s2_busy_cycles", busy_cyc, 41);
    check("s2_queue_empty", exp_q.size(), 0);

    // Five-cycle stall on the length word.
    len_stall = 5; busy_cyc = 0; acc_writes = 0;
    push_frame(2, NL);
    pulse_start(1'b0);
    wait_idle(100);
    check("s3_frame_count", frame_count, 3);
    check("s3_busy_cycles", busy_cyc, 26);
    check("s3_writes", acc_writes, 12);
    check("s3_stall_used", len_stall, 0);
    check("s3_queue_empty", exp_q.size(), 0);

    // Stop during the write-address word of line 1.
    busy_cyc = 0; acc_writes = 0; fd0 = fd_pulses;
    push_frame(3, 2);
    pulse_start(1'b0);
    n = 0;
    while (!(bus.desc_write && bus.desc_address == 2'd1 && acc_writes == 6) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("s4_reached_line1_waddr", acc_writes, 6);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(100);
    check("s4_frame_count", frame_count, 3);
    check("s4_no_frame_done", fd_pulses - fd0, 0);
    check("s4_writes", acc_writes, 8);
    check("s4_busy_cycles", busy_cyc, 14);
    check("s4_queue_empty", exp_q.size(), 0);

    // Continuous, two frames; stop coincident with start is discarded.
    continuous = 1'b1; busy_cyc = 0; raddr_log.delete();
    push_frame(3, NL); push_frame(4, NL);
    pulse_start(1'b1);
    n = 0;
    while (!frame_done && n < 60) begin
      @(negedge clk); #1; n++;
    end
    check("s5_count_at_first_done", frame_count, 4);
    continuous = 1'b0;
    wait_idle(100);
    check("s5_frame_count", frame_count, 5);
    check("s5_busy_cycles", busy_cyc, 42);
    check("s5_queue_empty", exp_q.size(), 0);
    check("s5_raddr_count", raddr_log.size(), 6);
    check("s5_frame_a_line0", raddr_log[0], DB ? 32'h3000_0180 : 32'h3000_0000);
    check("s5_frame_b_line0", raddr_log[3], 32'h3000_0000);

    // Reset during WR_RADDR, then a clean restart.
    push_frame(5, NL);
    pulse_start(1'b0);
    n = 0;
    while (!(bus.desc_write && bus.desc_address == 2'd0) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("s6_reached_raddr", bus.desc_write, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    raddr_log.delete();
    push_frame(0, NL);
    pulse_start(1'b0);
    wait_idle(100);
    check("s6_frame_count", frame_count, 1);
    check("s6_queue_empty", exp_q.size(), 0);
    check("s6_restart_line0", raddr_log[0], 32'h3000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/msgdma_frame_sequencer.md
# msgdma_frame_sequencer

Descriptor scheduler for the FPGA-side mSGDMA (memory-mapped to streaming). It walks a frame buffer in HPS SDRAM line by line and writes one standard descriptor per line into the dispatcher's descriptor slave, so the 256-bit stream source produces a framed stream with SOP on line 0 and EOP on the last line. It throttles on the dispatcher's descriptor-buffer-full status and supports single-shot and continuous frame modes.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: byte address of frame buffer 0 in SDRAM.
- `LINE_BYTES`, default 4096: descriptor length per line; must be a multiple of 32, the 256-bit beat size.
- `STRIDE_BYTES`, default 4096: address increment between lines; must be ≥ LINE_BYTES.
- `NUM_LINES`, default 1080: lines per frame, range 1..65535.
- `clk`  in  1: single clock, FPGA_CLK1_50 domain.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: pulse; starts a frame when idle. Ignored otherwise.
- `continuous`  in  1: when high at frame end, the next frame starts immediately.
- `stop`  in  1: pulse; finishes the current descriptor, then returns to IDLE.
- `busy`  out  1: high in any state other than IDLE.
- `frame_done`  out  1: one-cycle pulse after the last descriptor's control word is accepted.
- `frame_count`  out  16: number of completed frames; wraps modulo 2^16.
- `csr_address`  out  3: dispatcher CSR word address. Always 0, the status register.
- `csr_read`  out  1: CSR read request.
- `csr_waitrequest`  in  1: CSR stall.
- `csr_readdata`  in  32: CSR data. Bit 2 = descriptor buffer full.
- `desc_address`  out  2: descriptor slave word address.
- `desc_write`  out  1: descriptor write request.
- `desc_writedata`  out  32: descriptor word.
- `desc_waitrequest`  in  1: descriptor slave stall.

## Operation
- States: IDLE, POLL, POLL_WAIT, WR_RADDR, WR_WADDR, WR_LEN, WR_CTRL, NEXT.
- IDLE: `start` → POLL. At this point line=0, rd_addr=frame base, stop_pend=0.
- POLL: assert `csr_read` until `csr_waitrequest` is low, then → POLL_WAIT.
- POLL_WAIT: sample `csr_readdata`.
  - Bit 2 = 1 → POLL (re-poll).
  - Otherwise → WR_RADDR.
- WR_RADDR: write rd_addr to address 0.
- WR_WADDR: write 0 to address 1. This field is unused in MM→ST mode.
- WR_LEN: write LINE_BYTES to address 2.
- WR_CTRL: write to address 3. The word is bit31 go, bit8 = (line==0) for SOP, bit9 = (line==NUM_LINES-1) for EOP; all other bits 0.
- Each WR_* state holds `desc_write`, address and data stable until a cycle with `desc_waitrequest` low, then advances.
- NEXT:
  - Not the last line: line++, rd_addr += STRIDE_BYTES. Then → IDLE if stop_pend, else → POLL.
  - Last line: pulse `frame_done`, increment `frame_count`, reset line and rd_addr to the next frame base. Then → POLL if `continuous` && !stop_pend, else → IDLE.
- `stop` in any non-IDLE state sets stop_pend. A descriptor is never left partially written.
- `stop` and `start` together in IDLE: `start` wins and stop is discarded.
- rd_addr is 32-bit with an accumulator add (no multiplier). Overflow past 2^32 is not checked; this is the integrator's responsibility.

## Timing
- Reset values: `busy` 0, `frame_done` 0, `frame_count` 0, `csr_read` 0, `csr_address` 0, `desc_write` 0, `desc_address` 0, `desc_writedata` 0. Internal state is IDLE, line 0, stop_pend 0.
- All outputs are registered.
- CSR reads have fixed read latency 1: `csr_readdata` is valid the cycle after the accepted read.
- Minimum cost per descriptor with no stalls is 7 cycles: 1 POLL + 1 POLL_WAIT + 4 writes + 1 NEXT.
- `start` in cycle N → `busy` and `csr_read` high in cycle N+1.
- `rst` mid-frame aborts immediately: outputs return to reset values the next cycle. The dispatcher is not flushed; software resets the mSGDMA.

## Configuration
- `FRAME_SEQ_DOUBLE_BUFFER_EN` defined: frame base alternates between BASE_ADDR (even frame_count) and BASE_ADDR + NUM_LINES*STRIDE_BYTES (odd frame_count). The constant is computed at elaboration.
- Undefined: every frame starts at BASE_ADDR.

## Test plan
- NUM_LINES=3, LINE_BYTES=64, STRIDE=128, no stalls, pulse `start`:
  - Writes are {0x3000_0000, 0, 64, 0x8000_0100}, then {0x3000_0080, 0, 64, 0x8000_0000}, then {0x3000_0100, 0, 64, 0x8000_0200}.
  - `frame_done` pulses once; `frame_count`=1; `busy` drops.
- Status bit 2 held at 1 for 10 polls, then 0: no `desc_write` during that time, then the normal descriptor follows.
- `desc_waitrequest` high for 5 cycles during WR_LEN: address and data stay constant, and the word is written exactly once.
- `stop` pulsed during WR_WADDR of line 1: WR_LEN and WR_CTRL for line 1 complete, then IDLE; `frame_done` does not pulse.
- `continuous`=1, NUM_LINES=2, two frames:
  - Back-to-back frames with `frame_count` 1 then 2.
  - With `FRAME_SEQ_DOUBLE_BUFFER_EN`, the second frame's line 0 address is 0x3000_0000 + 2*STRIDE.
- `rst` asserted during WR_RADDR: the next cycle all outputs are at reset values; a subsequent `start` begins again at line 0.
